sha256_flex: RTL and testbench

SHA256_FLEX -- requirements
Module: sha256_flex

---
 rtl/sha256_flex_if.sv | 32 +++
 rtl/sha256_flex.sv | 174 +++++++++++++++++
 tb/tb_sha256_flex.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sha256_flex_if.sv
// Host/memory bus of sha256_flex: job request, status, and a single-port word memory.
// The slave modport is the hashing core's view; the master is the host-plus-memory side.
interface sha256_flex_if #(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 16
);
   logic              start;
   logic [LEN_W-1:0]  num_words;
   logic [ADDR_W-1:0] message_addr;
   logic [ADDR_W-1:0] output_addr;
   logic              use_midstate;
   logic [255:0]      midstate_in;
   logic              busy;
   logic              done;
   logic              mem_clk;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   modport slave (
      input  start, num_words, message_addr, output_addr, use_midstate, midstate_in,
      input  mem_read_data,
      output busy, done, mem_clk, mem_we, mem_addr, mem_write_data
   );

   modport master (
      output start, num_words, message_addr, output_addr, use_midstate, midstate_in,
      output mem_read_data,
      input  busy, done, mem_clk, mem_we, mem_addr, mem_write_data
   );
endinterface

// File: rtl/sha256_flex.sv
// Iterative SHA-256 engine: fetches a message of any length from word memory, pads it
// on the fly, runs one round per cycle and writes the 8-word digest back to memory.
module sha256_flex #(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   sha256_flex_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, UPDATE, WRITE, DONE} state_t;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t            state_q, state_d;
   logic [5:0]        cnt_q;
   logic [LEN_W:0]    blk_q, blk_next, nb;
   logic [LEN_W-1:0]  num_q;
   logic [ADDR_W-1:0] msg_q, out_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [31:0]       hs_q [8];
   logic [31:0]       v_q [8];
   logic [31:0]       w_q [16];
   logic [255:0]      init_hash;
   logic [3:0]        slot;
   logic [LEN_W+4:0]  p_cur, p_next, p_blk, num_ext;
   logic              last_blk;
   logic [31:0]       pad_word, t1, t2, w_new;

   assign init_hash = bus.use_midstate ? bus.midstate_in : IV;
   assign nb        = (({1'b0, num_q} + (LEN_W+1)'(2)) >> 4) + (LEN_W+1)'(1);
   assign last_blk  = (blk_q == nb - (LEN_W+1)'(1));
   assign blk_next  = blk_q + (LEN_W+1)'(1);
   assign num_ext   = {4'b0000, num_q};
   // A FETCH cycle c captures the word addressed in cycle c-1; c=0 wraps to slot 15 unused.
   assign slot      = cnt_q[3:0] - 4'd1;
   assign p_cur     = {blk_q, slot};
   assign p_next    = {blk_q, cnt_q[3:0] + 4'd1};
   assign p_blk     = {blk_next, 4'd0};

   assign bus.mem_clk        = clk;
   assign bus.busy           = (state_q != IDLE);
   assign bus.done           = (state_q == DONE);
   assign bus.mem_we         = (state_q == WRITE);
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_write_data = mem_wdata_q;

   always_comb begin
      pad_word = 32'h0;
      if (p_cur < num_ext)
         pad_word = bus.mem_read_data;
      else if (p_cur == num_ext)
         pad_word = 32'h8000_0000;
      else if (last_blk && slot == 4'd15)
         pad_word = 32'({num_q, 5'b00000});
   end

   always_comb begin
      t1 = v_q[7] + big_sigma1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[cnt_q] + w_q[0];
      t2 = big_sigma0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
      w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = FETCH;
         FETCH:   if (cnt_q == 6'd16) state_d = COMPUTE;
         COMPUTE: if (cnt_q == 6'd63) state_d = UPDATE;
         UPDATE:  state_d = last_blk ? WRITE : FETCH;
         WRITE:   if (cnt_q == 6'd7) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         blk_q       <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_d != state_q) ? 6'd0 : cnt_q + 6'd1;
         case (state_q)
            IDLE: if (bus.start) begin
               blk_q <= '0;
               if (bus.num_words != '0) mem_addr_q <= bus.message_addr;
            end
            FETCH: if (cnt_q < 6'd15 && p_next < num_ext)
               mem_addr_q <= msg_q + ADDR_W'(p_next);
            UPDATE: if (last_blk) begin
               mem_addr_q  <= out_q;
               mem_wdata_q <= hs_q[0] + v_q[0];
            end else begin
               blk_q <= blk_next;
               if (p_blk < num_ext) mem_addr_q <= msg_q + ADDR_W'(p_blk);
            end
            WRITE: if (cnt_q != 6'd7) begin
               mem_addr_q  <= out_q + ADDR_W'(cnt_q + 6'd1);
               mem_wdata_q <= hs_q[cnt_q[2:0] + 3'd1];
            end
            default: ;
         endcase
      end
   end

   // Hash state, working variables and schedule window carry no reset; start reloads them.
   always_ff @(posedge clk) begin
      case (state_q)
         IDLE: if (bus.start) begin
            num_q <= bus.num_words;
            msg_q <= bus.message_addr;
            out_q <= bus.output_addr;
            for (int i = 0; i < 8; i++) begin
               hs_q[i] <= init_hash[255 - 32*i -: 32];
               v_q[i]  <= init_hash[255 - 32*i -: 32];
            end
         end
         FETCH: if (cnt_q != 6'd0) w_q[slot] <= pad_word;
         COMPUTE: begin
            v_q[0] <= t1 + t2;
            v_q[1] <= v_q[0];
            v_q[2] <= v_q[1];
            v_q[3] <= v_q[2];
            v_q[4] <= v_q[3] + t1;
            v_q[5] <= v_q[4];
            v_q[6] <= v_q[5];
            v_q[7] <= v_q[6];
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_new;
         end
         UPDATE: for (int i = 0; i < 8; i++) begin
            hs_q[i] <= hs_q[i] + v_q[i];
            v_q[i]  <= hs_q[i] + v_q[i];
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_sha256_flex.sv
// Bench for sha256_flex: word memory model, full-message SHA-256 reference, and
// directed scenarios for padding, midstate, ignored starts, address wrap and reset abort.
module tb_sha256_flex;
   localparam logic [255:0] IV_STD = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_ABCD  = 256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] mem [65536];
   logic [15:0] wa[$];
   logic [31:0] wd[$];
   logic [15:0] ra[$];

   sha256_flex_if #(.LEN_W(16), .ADDR_W(16)) bus ();

   sha256_flex #(.LEN_W(16), .ADDR_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory; logs writes, and distinct read addresses until the first write.
   always @(posedge clk) begin
      if (bus.mem_we) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_write_data);
      end else if (bus.busy && wa.size() == 0 && (ra.size() == 0 || ra[$] != bus.mem_addr)) begin
         ra.push_back(bus.mem_addr);
      end
      bus.mem_read_data <= mem[bus.mem_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straight from the standard: pad the whole message, expand 64 words per block, compress.
   function automatic void ref_hash(input logic [31:0] msg[$], input logic [255:0] iv,
                                    output logic [255:0] dig, output int nblk);
      logic [31:0] pad[$];
      logic [31:0] w [64];
      logic [31:0] h [8];
      logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
      pad = msg;
      pad.push_back(32'h8000_0000);
      while (pad.size() % 16 != 14) pad.push_back(32'h0);
      pad.push_back(32'h0);
      pad.push_back(32'(msg.size() * 32));
      nblk = pad.size() / 16;
      for (int i = 0; i < 8; i++) h[i] = iv[255 - 32*i -: 32];
      for (int bk = 0; bk < nblk; bk++) begin
         for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = pad[16*bk + t];
            else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
         end
         a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
         for (int t = 0; t < 64; t++) begin
            x1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
         end
         h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
      end
      dig = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
   endfunction

   task automatic run_hash(input string tag, input int num, input logic [15:0] maddr, input logic [15:0] oaddr,
                           input bit usemid, input logic [255:0] mid, input bit rnd,
                           input bit use_const, input logic [255:0] cexp, input bit noisy);
      logic [31:0]  msg[$];
      logic [255:0] exp_d;
      logic [15:0]  ad;
      int           nblk, n;
      bit           got;
      for (int i = 0; i < num; i++) begin
         ad = maddr + 16'(i);
         if (rnd) mem[ad] = $urandom;
         msg.push_back(mem[ad]);
      end
      ref_hash(msg, usemid ? mid : IV_STD, exp_d, nblk);
      if (use_const) exp_d = cexp;
      wa.delete(); wd.delete(); ra.delete();
      @(negedge clk);
      bus.start = 1'b1; bus.num_words = 16'(num); bus.message_addr = maddr;
      bus.output_addr = oaddr; bus.use_midstate = usemid; bus.midstate_in = mid;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 1; got = 1'b0;
      while (!got && n < 2000) begin
         if (noisy && n % 23 == 5) begin
            bus.start = 1'b1; bus.num_words = 16'($urandom); bus.message_addr = 16'($urandom);
            bus.output_addr = 16'($urandom); bus.use_midstate = ~usemid; bus.midstate_in = {8{$urandom}};
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1 n++;
         if (bus.done) got = 1'b1;
      end
      bus.start = 1'b0;
      check({tag, " latency"}, 64'(n), 64'(82*nblk + 9));
      check({tag, " write count"}, 64'(wa.size()), 64'd8);
      for (int k = 0; k < 8; k++)
         check($sformatf("%s H%0d", tag, k),
               (wa.size() > k) ? {16'h0, wa[k], wd[k]} : 64'hx,
               {16'h0, oaddr + 16'(k), exp_d[255 - 32*k -: 32]});
      @(posedge clk);
      #1 check({tag, " idle after done"}, {62'h0, bus.busy, bus.done}, 64'h0);
   endtask

   initial begin
      logic [15:0]  prev;
      logic [255:0] rmid;
      int           cntw;
      reset_n = 1'b0;
      bus.start = 1'b0; bus.num_words = '0; bus.message_addr = '0; bus.output_addr = '0;
      bus.use_midstate = 1'b0; bus.midstate_in = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(bus.busy), 64'h0);
      check("reset done", 64'(bus.done), 64'h0);
      check("reset mem_we", 64'(bus.mem_we), 64'h0);
      check("reset mem_addr", 64'(bus.mem_addr), 64'h0);
      check("reset mem_write_data", 64'(bus.mem_write_data), 64'h0);
      reset_n = 1'b1;

      prev = bus.mem_addr;
      run_hash("empty", 0, 16'h0040, 16'h1000, 1'b0, '0, 1'b0, 1'b1, D_EMPTY, 1'b0);
      check("empty no reads", {48'h0, (ra.size() == 1) ? ra[0] : 16'hx}, {48'h0, prev});

      mem[16'h0200] = 32'h6162_6364;
      run_hash("abcd", 1, 16'h0200, 16'h1010, 1'b0, '0, 1'b0, 1'b1, D_ABCD, 1'b0);
      run_hash("abcd midstate", 1, 16'h0200, 16'h1020, 1'b1, IV_STD, 1'b0, 1'b1, D_ABCD, 1'b0);

      run_hash("rand13", 13, 16'h0300, 16'h1030, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      run_hash("rand14 noisy", 14, 16'h0400, 16'h1040, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      run_hash("rand20 noisy", 20, 16'h0500, 16'h1050, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      rmid = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_hash("rand7 midstate", 7, 16'h0600, 16'h1060, 1'b1, rmid, 1'b1, 1'b0, '0, 1'b0);

      run_hash("wrap", 4, 16'hFFFE, 16'h1070, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      check("wrap reads", (ra.size() == 4) ? {ra[0], ra[1], ra[2], ra[3]} : 64'hx, 64'hFFFE_FFFF_0000_0001);

      // Abort during COMPUTE with extra start pulses beforehand, then restart the same message.
      for (int i = 0; i < 5; i++) mem[16'h0700 + 16'(i)] = $urandom;
      @(negedge clk);
      bus.start = 1'b1; bus.num_words = 16'd5; bus.message_addr = 16'h0700;
      bus.output_addr = 16'h1080; bus.use_midstate = 1'b0;
      @(negedge clk) bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (30) @(negedge clk);
      wa.delete(); wd.delete();
      reset_n = 1'b0;
      #1 check("abort compute busy", 64'(bus.busy), 64'h0);
      @(negedge clk) reset_n = 1'b1;
      repeat (150) @(negedge clk);
      check("abort compute no writes", 64'(wa.size()), 64'h0);
      run_hash("restart after compute abort", 5, 16'h0700, 16'h1080, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

      // Abort in the fourth WRITE cycle: three words already out, nothing after.
      wa.delete(); wd.delete();
      @(negedge clk);
      bus.start = 1'b1; bus.num_words = 16'd0; bus.output_addr = 16'h1090; bus.use_midstate = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (85) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      cntw = wa.size();
      #1 check("abort write mem_we", {62'h0, bus.mem_we, bus.busy}, 64'h0);
      check("abort write words before reset", 64'(cntw), 64'd3);
      @(negedge clk) reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort write no further writes", 64'(wa.size()), 64'(cntw));
      run_hash("restart after write abort", 0, 16'h0000, 16'h10A0, 1'b0, '0, 1'b0, 1'b1, D_EMPTY, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
